// File: rtl/apb_regfile_bridge.sv
// APB3 slave front-end for a generated register file: one write port, first read port.
// Optional feature macro: APB_BRIDGE_PSTRB_EN forwards pstrb to wr_be_0; when undefined,
// every write enables all byte lanes.
// Every output is a register, so each output's next value is decided one cycle ahead.
module apb_regfile_bridge #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] PARK_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W+1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                wr_en_0,
  output logic [ADDR_W-1:0]   wr_addr_0,
  output logic [DATA_W-1:0]   wr_data_0,
  output logic [DATA_W/8-1:0] wr_be_0,
  output logic [ADDR_W-1:0]   rd_addr_0,
  input  logic [DATA_W-1:0]   rd_data_0
);

  localparam int unsigned     BeW      = DATA_W / 8;
  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StWrite, StRdAddr, StRdResp} state_e;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [BeW-1:0]    wr_be_q, wr_be_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [ADDR_W-1:0] widx;
  logic              setup_err;
  logic [BeW-1:0]    setup_be;

  assign widx      = paddr[ADDR_W+1:2];
  assign setup_err = ({1'b0, widx} >= NumRegsW);

`ifdef APB_BRIDGE_PSTRB_EN
  logic unused_bits;
  assign setup_be    = pstrb;
  assign unused_bits = ^paddr[1:0];
`else
  logic unused_bits;
  assign setup_be    = '1;
  assign unused_bits = ^{paddr[1:0], pstrb};
`endif

  // Next-state and next-output decode; pulses default low, rd_addr defaults to park.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    rd_addr_d = PARK_ADDR;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          err_d = setup_err;
          if (pwrite) begin
            // Strobe and completion are loaded now so they appear in the access cycle.
            state_d   = StWrite;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            wr_en_d   = !setup_err;
            wr_addr_d = widx;
            wr_data_d = pwdata;
            wr_be_d   = setup_be;
          end else begin
            state_d   = StRdAddr;
            rd_addr_d = setup_err ? PARK_ADDR : widx;
          end
        end
      end
      StWrite: state_d = StIdle;
      StRdAddr: begin
        if (!psel) begin
          // Aborted read: no completion and prdata keeps its previous value.
          state_d = StIdle;
        end else begin
          state_d   = StRdResp;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = err_q ? '0 : rd_data_0;
        end
      end
      StRdResp: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      rd_addr_q <= PARK_ADDR;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign wr_en_0   = wr_en_q;
  assign wr_addr_0 = wr_addr_q;
  assign wr_data_0 = wr_data_q;
  assign wr_be_0   = wr_be_q;
  assign rd_addr_0 = rd_addr_q;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// Self-checking bench for apb_regfile_bridge: directed table, corner sequences, random traffic.
// A small regfile with a read-clear word 2 sits behind the bridge.
module tb_apb_regfile_bridge;

  localparam logic [7:0] Park = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        wr_en_0;
  logic [7:0]  wr_addr_0;
  logic [31:0] wr_data_0;
  logic [3:0]  wr_be_0;
  logic [7:0]  rd_addr_0;
  logic [31:0] rd_data_0;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  logic [31:0] mem   [4];
  logic [31:0] model [4];

  always #5 clk = ~clk;

  apb_regfile_bridge #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .NUM_REGS (4),
    .PARK_ADDR(8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .wr_en_0  (wr_en_0),
    .wr_addr_0(wr_addr_0),
    .wr_data_0(wr_data_0),
    .wr_be_0  (wr_be_0),
    .rd_addr_0(rd_addr_0),
    .rd_data_0(rd_data_0)
  );

  // Environment regfile: byte-enabled writes, word 2 clears whenever it is addressed.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (wr_en_0 && wr_addr_0 < 8'd4)
        for (int b = 0; b < 4; b++)
          if (wr_be_0[b]) mem[wr_addr_0[1:0]][8*b +: 8] <= wr_data_0[8*b +: 8];
      if (rd_addr_0 == 8'd2) mem[2] <= '0;
    end
  end

  assign rd_data_0 = (rd_addr_0 < 8'd4) ? mem[rd_addr_0[1:0]] : 32'hBAD0_BAD0;

  // Count strobe cycles and non-parked read-address cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_0) wr_pulses <= wr_pulses + 1;
    if (rd_addr_0 != Park) rd_pulses <= rd_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] eff_be(input logic [3:0] strb);
`ifdef APB_BRIDGE_PSTRB_EN
    return strb;
`else
    return 4'hF;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    tick();
  endtask

  // Full write transfer; returns in the cycle after pready with the bus still in access.
  task automatic do_write(input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    logic [7:0] widx;
    logic       err;
    int         w0, r0;
    widx = addr[9:2];
    err  = (widx >= 8'd4);
    w0 = wr_pulses;
    r0 = rd_pulses;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = addr; pwdata = data; pstrb = strb;
    tick();
    penable = 1'b1;
    check("wr_pready_t1", 32'(pready), 32'd1);
    check("wr_pslverr_t1", 32'(pslverr), 32'(err));
    check("wr_en_t1", 32'(wr_en_0), 32'(!err));
    if (!err) begin
      check("wr_addr_t1", 32'(wr_addr_0), 32'(widx));
      check("wr_data_t1", wr_data_0, data);
      check("wr_be_t1", 32'(wr_be_0), 32'(eff_be(strb)));
      model[widx[1:0]] = merge(model[widx[1:0]], data, eff_be(strb));
    end
    tick();
    check("wr_en_t2", 32'(wr_en_0), 32'd0);
    check("wr_pready_t2", 32'(pready), 32'd0);
    check("wr_strobe_count", 32'(wr_pulses - w0), err ? 32'd0 : 32'd1);
    check("wr_no_rd_addr", 32'(rd_pulses - r0), 32'd0);
  endtask

  // Full read transfer; returns in the cycle after pready.
  task automatic do_read(input logic [9:0] addr, input logic [31:0] exp);
    logic [7:0] widx;
    logic       err;
    int         w0, r0;
    widx = addr[9:2];
    err  = (widx >= 8'd4);
    w0 = wr_pulses;
    r0 = rd_pulses;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    tick();
    penable = 1'b1;
    check("rd_addr_t1", 32'(rd_addr_0), err ? 32'(Park) : 32'(widx));
    check("rd_pready_t1", 32'(pready), 32'd0);
    tick();
    check("rd_pready_t2", 32'(pready), 32'd1);
    check("rd_pslverr_t2", 32'(pslverr), 32'(err));
    check("rd_prdata_t2", prdata, exp);
    check("rd_addr_parked_t2", 32'(rd_addr_0), 32'(Park));
    tick();
    check("rd_pready_t3", 32'(pready), 32'd0);
    check("rd_prdata_hold_t3", prdata, exp);
    check("rd_addr_count", 32'(rd_pulses - r0), err ? 32'd0 : 32'd1);
    check("rd_no_strobe", 32'(wr_pulses - w0), 32'd0);
    if (!err && widx == 8'd2) model[2] = '0;
  endtask

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0]  ridx;
    logic [9:0]  raddr;
    logic [31:0] rdat, rexp;
    logic [3:0]  rstrb;

    vecs[0]  = '{1'b1, 10'h004, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 10'h008, 32'h0000A5A5, 32'h0};
    vecs[3]  = '{1'b0, 10'h008, 32'h0,        32'h0000A5A5};
    vecs[4]  = '{1'b0, 10'h008, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 10'h010, 32'h12345678, 32'h0};
    vecs[6]  = '{1'b0, 10'h010, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 10'h00C, 32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1'b0, 10'h00C, 32'h0,        32'hCAFEF00D};
    vecs[9]  = '{1'b0, 10'h3FC, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 10'h000, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 10'h007, 32'h11112222, 32'h0};
    vecs[12] = '{1'b0, 10'h005, 32'h0,        32'h11112222};

    for (int i = 0; i < 4; i++) model[i] = '0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    tick();
    tick();
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_wr_en", 32'(wr_en_0), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_0), 32'd0);
    check("rst_wr_data", wr_data_0, 32'd0);
    check("rst_wr_be", 32'(wr_be_0), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_0), 32'hFF);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, 4'hF);
      else            do_read(vecs[i].addr, vecs[i].exp);
      idle();
    end

    // Partial byte strobes.
    do_write(10'h000, 32'hAABBCCDD, 4'hF);
    idle();
    do_write(10'h000, 32'h11223344, 4'b0101);
    idle();
`ifdef APB_BRIDGE_PSTRB_EN
    do_read(10'h000, 32'hAA22CC44);
`else
    do_read(10'h000, 32'h11223344);
`endif
    idle();

    // Back-to-back: read setup in the cycle right after the write's pready.
    do_write(10'h00C, 32'h5A5A0001, 4'hF);
    do_read(10'h00C, 32'h5A5A0001);
    idle();

    // psel dropped during RD_ADDR: no completion, prdata keeps its old value.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h004;
    tick();
    check("abort_rd_addr_t1", 32'(rd_addr_0), 32'd1);
    psel = 1'b0;
    tick();
    check("abort_pready_t2", 32'(pready), 32'd0);
    check("abort_rd_addr_t2", 32'(rd_addr_0), 32'(Park));
    check("abort_prdata_hold", prdata, 32'h5A5A0001);
    tick();
    check("abort_pready_t3", 32'(pready), 32'd0);

    // Reset during RD_ADDR, then a normal transfer pair.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h00C;
    tick();
    penable = 1'b1;
    check("rstmid_rd_addr_t1", 32'(rd_addr_0), 32'd3);
    rst = 1'b1;
    tick();
    check("rstmid_rd_addr", 32'(rd_addr_0), 32'(Park));
    check("rstmid_pready", 32'(pready), 32'd0);
    check("rstmid_prdata", prdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    idle();
    do_write(10'h004, 32'h0BADF00D, 4'hF);
    idle();
    do_read(10'h004, 32'h0BADF00D);
    idle();

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      ridx  = 8'($urandom_range(0, 5));
      raddr = {ridx, 2'($urandom_range(0, 3))};
      rdat  = $urandom;
      rstrb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(raddr, rdat, rstrb);
      end else begin
        rexp = (ridx < 8'd4) ? model[ridx[1:0]] : 32'd0;
        do_read(raddr, rexp);
      end
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
